// File: rtl/cw_keying_decoder.sv
// cw_keying_decoder
//   Receive-side Morse decoder. The keyed line is synchronized and
//   glitch-filtered into a clean level. Mark and space lengths are then
//   timed in clock cycles, and each mark is classified as a dot or a dash.
//   Elements are collected into a character, and one-cycle strobes report
//   each finished character, each inter-word gap and each error.
//
// Parameters
//   UNIT_CYCLES    one Morse unit (dot length) in CLK cycles
//   GLITCH_CYCLES  cycles a new level must persist before it is accepted
//   CNT_W          duration counter width, 2**CNT_W > 8*UNIT_CYCLES
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   KEY_IN      keyed line, 1 = mark; asynchronous to CLK
//   CHAR_VALID  one-cycle strobe, CHAR_LEN/CHAR_BITS updated this cycle
//   CHAR_LEN    element count of the last decoded character (1..6)
//   CHAR_BITS   element i at bit i, 1 = dash, unused bits 0
//   WORD_GAP    one-cycle strobe on an inter-word space
//   ERR         one-cycle strobe on element overflow or stuck key
module cw_keying_decoder #(
  parameter int UNIT_CYCLES   = 12500,
  parameter int GLITCH_CYCLES = 250,
  parameter int CNT_W         = 17
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_IN,
  output logic       CHAR_VALID,
  output logic [2:0] CHAR_LEN,
  output logic [5:0] CHAR_BITS,
  output logic       WORD_GAP,
  output logic       ERR
);

  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam logic [GW-1:0]    GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_MIN    = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_LAST   = CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LAST   = CNT_W'(5 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST  = CNT_W'(8 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(8 * UNIT_CYCLES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MARK    = 2'd1;
  localparam logic [1:0] ST_SPACE   = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  logic             sync_a;
  logic             sync_b;
  logic             lvl;
  logic [GW-1:0]    glitch_cnt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic [2:0]       elem_cnt;
  logic [5:0]       elem_bits;

  logic lvl_flip;
  logic rise;
  logic fall;
  logic hit_dash;
  logic hit_word;
  logic hit_stuck;

  // Level changes and threshold crossings are decoded in the same cycle
  // that lvl and cnt are updated. A threshold is "reached" on the edge
  // where cnt steps onto it. A level edge in that same cycle clears cnt
  // first, so the edge wins over the crossing.
  always_comb begin
    lvl_flip  = (sync_b != lvl) && (glitch_cnt == GLITCH_LAST);
    rise      = lvl_flip && !lvl;
    fall      = lvl_flip && lvl;
    hit_dash  = !lvl_flip && (cnt == DASH_LAST);
    hit_word  = !lvl_flip && (cnt == WORD_LAST);
    hit_stuck = !lvl_flip && (cnt == STUCK_LAST);
  end

  // Two-flop synchronizer followed by the glitch filter. The filter counts
  // consecutive cycles in which the synchronized value disagrees with lvl.
  // A single agreeing cycle restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      lvl        <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      sync_a <= KEY_IN;
      sync_b <= sync_a;
      if (sync_b == lvl) begin
        glitch_cnt <= '0;
      end else if (lvl_flip) begin
        lvl        <= sync_b;
        glitch_cnt <= '0;
      end else begin
        glitch_cnt <= glitch_cnt + 1'b1;
      end
    end
  end

  // Duration of the current level. The counter saturates at the stuck-key
  // limit, so long idle periods cannot wrap it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (lvl_flip) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Element assembly and strobe generation. The strobes default low, so
  // each one is a single-cycle pulse. CHAR_LEN/CHAR_BITS hold between
  // characters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      elem_cnt   <= '0;
      elem_bits  <= '0;
      CHAR_VALID <= 1'b0;
      CHAR_LEN   <= '0;
      CHAR_BITS  <= '0;
      WORD_GAP   <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      CHAR_VALID <= 1'b0;
      WORD_GAP   <= 1'b0;
      ERR        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_MARK;
          end
        end
        ST_MARK: begin
          if (fall) begin
            if (elem_cnt == 3'd6) begin
              ERR       <= 1'b1;
              elem_cnt  <= '0;
              elem_bits <= '0;
              state     <= ST_DISCARD;
            end else begin
              elem_bits[elem_cnt] <= (cnt >= DASH_MIN);
              elem_cnt            <= elem_cnt + 3'd1;
              state               <= ST_SPACE;
            end
          end else if (hit_stuck) begin
            ERR       <= 1'b1;
            elem_cnt  <= '0;
            elem_bits <= '0;
            state     <= ST_DISCARD;
          end
        end
        ST_SPACE: begin
          if (rise) begin
            state <= ST_MARK;
          end else if (hit_dash && (elem_cnt != 3'd0)) begin
            CHAR_VALID <= 1'b1;
            CHAR_LEN   <= elem_cnt;
            CHAR_BITS  <= elem_bits;
            elem_cnt   <= '0;
            elem_bits  <= '0;
          end else if (hit_word && (elem_cnt == 3'd0)) begin
            WORD_GAP <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          // Discard: leave only after a quiet low period of two units.
          if (!lvl && hit_dash) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cw_keying_decoder.sv
// tb_cw_keying_decoder
//   Drives KEY_IN as a list of timed segments and predicts every strobe
//   from the segment lengths. The prediction works on level durations:
//   glitches are merged into their neighbours, and each remaining edge is
//   shifted by the input latency.
module tb_cw_keying_decoder;

  localparam int U  = 20;
  localparam int G  = 4;
  localparam int CW = 8;
  localparam int INF = 32'h3fffffff;

  typedef struct {
    bit lev;
    int len;
    bit glitch;
  } seg_t;

  typedef struct {
    int kind;
    int t;
    int len;
    int bits;
  } ev_t;

  logic       CLK;
  logic       RST;
  logic       KEY_IN;
  logic       CHAR_VALID;
  logic [2:0] CHAR_LEN;
  logic [5:0] CHAR_BITS;
  logic       WORD_GAP;
  logic       ERR;

  seg_t segs[$];
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  int   n_cmp;
  int   n_fail;
  int   cyc;
  bit   mon_en;
  int   last_len;
  int   last_bits;

  cw_keying_decoder #(
    .UNIT_CYCLES  (U),
    .GLITCH_CYCLES(G),
    .CNT_W        (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .KEY_IN    (KEY_IN),
    .CHAR_VALID(CHAR_VALID),
    .CHAR_LEN  (CHAR_LEN),
    .CHAR_BITS (CHAR_BITS),
    .WORD_GAP  (WORD_GAP),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Record every strobe with the cycle it appeared in.
  always @(negedge CLK) begin
    if (mon_en && !RST && (CHAR_VALID || WORD_GAP || ERR)) begin
      check_output("strobe_exclusive", int'(CHAR_VALID) + int'(WORD_GAP) + int'(ERR), 1);
      if (CHAR_VALID) obs_q.push_back('{kind: 0, t: cyc, len: int'(CHAR_LEN), bits: int'(CHAR_BITS)});
      if (WORD_GAP)   obs_q.push_back('{kind: 1, t: cyc, len: 0, bits: 0});
      if (ERR)        obs_q.push_back('{kind: 2, t: cyc, len: 0, bits: 0});
    end
  end

  task automatic add_seg(input bit lev, input int len, input bit glitch);
    segs.push_back('{lev: lev, len: len, glitch: glitch});
  endtask

  // Add a clean segment. Sometimes split it with a short opposite-level
  // glitch that the filter must swallow.
  task automatic add_maybe_glitch(input bit lev, input int len);
    int g;
    int a;
    if (len >= 3 * G + 4 && $urandom_range(0, 3) == 0) begin
      g = $urandom_range(1, G - 1);
      a = $urandom_range(G + 2, len - g - (G + 2));
      add_seg(lev, a, 1'b0);
      add_seg(!lev, g, 1'b1);
      add_seg(lev, len - a - g, 1'b0);
    end else begin
      add_seg(lev, len, 1'b0);
    end
  endtask

  // Expected strobes from the accepted level edges and the decoding rules.
  // D is the cycle count between edges minus one, and a threshold counts as
  // reached only if the level is still unchanged on that cycle.
  task automatic build_model(input int t0);
    int  edges[$];
    int  lev;
    int  t;
    int  n;
    int  r;
    int  f;
    int  nr;
    int  d;
    int  blen;
    int  bbits;
    bit  discarding;
    exp_q.delete();
    lev = 0;
    t = t0;
    foreach (segs[j]) begin
      if (!segs[j].glitch && int'(segs[j].lev) != lev) begin
        edges.push_back(t + G + 2);
        lev = int'(segs[j].lev);
      end
      t += segs[j].len;
    end
    n = edges.size();
    blen = 0;
    bbits = 0;
    discarding = 1'b0;
    for (int i = 0; i + 1 < n; i += 2) begin
      r  = edges[i];
      f  = edges[i + 1];
      nr = (i + 2 < n) ? edges[i + 2] : INF;
      if (discarding) begin
        if (nr > f + 2 * U) discarding = 1'b0;
        continue;
      end
      if (f > r + 8 * U) begin
        exp_q.push_back('{kind: 2, t: r + 8 * U, len: 0, bits: 0});
        blen = 0;
        bbits = 0;
        discarding = !(nr > f + 2 * U);
        continue;
      end
      d = f - r - 1;
      if (blen == 6) begin
        exp_q.push_back('{kind: 2, t: f, len: 0, bits: 0});
        blen = 0;
        bbits = 0;
        discarding = !(nr > f + 2 * U);
        continue;
      end
      if (d >= 2 * U) bbits = bbits | (1 << blen);
      blen++;
      if (nr > f + 2 * U) begin
        exp_q.push_back('{kind: 0, t: f + 2 * U, len: blen, bits: bbits});
        last_len  = blen;
        last_bits = bbits;
        blen = 0;
        bbits = 0;
        if (nr > f + 5 * U) exp_q.push_back('{kind: 1, t: f + 5 * U, len: 0, bits: 0});
      end
    end
  endtask

  task automatic apply_stimulus();
    foreach (segs[j]) begin
      KEY_IN = segs[j].lev;
      repeat (segs[j].len) begin
        @(posedge CLK);
        #1;
      end
    end
    KEY_IN = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    KEY_IN = 1'b0;
    repeat (5) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
    check_output("rst_char_valid", int'(CHAR_VALID), 0);
    check_output("rst_char_len", int'(CHAR_LEN), 0);
    check_output("rst_char_bits", int'(CHAR_BITS), 0);
    check_output("rst_word_gap", int'(WORD_GAP), 0);
    check_output("rst_err", int'(ERR), 0);
  endtask

  task automatic run_phase(input bit do_reset, input string name);
    int m;
    if (do_reset) reset_dut();
    last_len  = 0;
    last_bits = 0;
    obs_q.delete();
    build_model(cyc);
    apply_stimulus();
    check_output({name, ":count"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_output({name, ":kind"}, obs_q[i].kind, exp_q[i].kind);
      check_output({name, ":time"}, obs_q[i].t, exp_q[i].t);
      check_output({name, ":len"}, obs_q[i].len, exp_q[i].len);
      check_output({name, ":bits"}, obs_q[i].bits, exp_q[i].bits);
    end
    check_output({name, ":held_len"}, int'(CHAR_LEN), last_len);
    check_output({name, ":held_bits"}, int'(CHAR_BITS), last_bits);
  endtask

  task automatic gen_random();
    int nchar;
    int nel;
    int pick;
    int len;
    segs.delete();
    add_seg(1'b0, G + 2 + $urandom_range(0, 10), 1'b0);
    nchar = $urandom_range(1, 4);
    for (int c = 0; c < nchar; c++) begin
      nel = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(1, 6);
      for (int e = 0; e < nel; e++) begin
        pick = $urandom_range(0, 9);
        case (pick)
          0, 1, 2, 3: len = $urandom_range(G + 2, 2 * U - 2);
          4, 5, 6:    len = $urandom_range(2 * U + 2, 6 * U);
          7:          len = 2 * U;
          8:          len = 2 * U + 1;
          default:    len = ($urandom_range(0, 2) == 0) ? 8 * U + $urandom_range(1, 2 * U) : 8 * U;
        endcase
        add_maybe_glitch(1'b1, len);
        if (e < nel - 1) begin
          len = ($urandom_range(0, 4) == 0) ? 2 * U : $urandom_range(G + 2, 2 * U);
          add_maybe_glitch(1'b0, len);
        end
      end
      pick = $urandom_range(0, 7);
      case (pick)
        0:       len = 2 * U;
        1:       len = 2 * U + 1;
        2:       len = 5 * U;
        3:       len = 5 * U + 1;
        default: len = $urandom_range(2 * U + 1, 7 * U);
      endcase
      add_maybe_glitch(1'b0, len);
    end
    add_seg(1'b0, 6 * U + G + 8, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    mon_en = 1'b0;
    RST    = 1'b1;
    KEY_IN = 1'b0;
    repeat (2) @(posedge CLK);
    mon_en = 1'b1;

    // Single dot 'E'
    segs.delete();
    add_seg(1'b0, 10, 1'b0); add_seg(1'b1, U, 1'b0); add_seg(1'b0, 6 * U + G + 8, 1'b0);
    run_phase(1'b1, "letter_e");

    // 'A': dot, one-unit space, dash
    segs.delete();
    add_seg(1'b0, 10, 1'b0); add_seg(1'b1, U, 1'b0); add_seg(1'b0, U, 1'b0);
    add_seg(1'b1, 3 * U, 1'b0); add_seg(1'b0, 6 * U + G + 8, 1'b0);
    run_phase(1'b1, "letter_a");

    // Short pulse on an idle line, then a dash with a short dropout
    segs.delete();
    add_seg(1'b0, 10, 1'b0); add_seg(1'b1, G / 2, 1'b1); add_seg(1'b0, 3 * U, 1'b0);
    add_seg(1'b1, U, 1'b0); add_seg(1'b0, G - 1, 1'b1); add_seg(1'b1, 2 * U - G + 1, 1'b0);
    add_seg(1'b0, 6 * U + G + 8, 1'b0);
    run_phase(1'b1, "glitches");

    // Seven dots overflow the buffer, then a clean 'E'
    segs.delete();
    add_seg(1'b0, 10, 1'b0);
    for (int i = 0; i < 7; i++) begin
      add_seg(1'b1, U, 1'b0);
      if (i < 6) add_seg(1'b0, U, 1'b0);
    end
    add_seg(1'b0, 5 * U, 1'b0); add_seg(1'b1, U, 1'b0); add_seg(1'b0, 6 * U + G + 8, 1'b0);
    run_phase(1'b1, "overflow");

    // Key held for twelve units
    segs.delete();
    add_seg(1'b0, 10, 1'b0); add_seg(1'b1, 12 * U, 1'b0); add_seg(1'b0, 6 * U + G + 8, 1'b0);
    run_phase(1'b1, "stuck_key");

    // Dot/dash and character-gap boundaries
    segs.delete();
    add_seg(1'b0, 10, 1'b0); add_seg(1'b1, 2 * U, 1'b0); add_seg(1'b0, 2 * U, 1'b0);
    add_seg(1'b1, 2 * U + 1, 1'b0); add_seg(1'b0, 2 * U + 1, 1'b0);
    add_seg(1'b1, U, 1'b0); add_seg(1'b0, 6 * U + G + 8, 1'b0);
    run_phase(1'b1, "boundary");

    // Reset during the space after a dash discards the partial character
    reset_dut();
    obs_q.delete();
    segs.delete();
    add_seg(1'b0, 10, 1'b0); add_seg(1'b1, 3 * U, 1'b0); add_seg(1'b0, U, 1'b0);
    apply_stimulus();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    segs.delete();
    add_seg(1'b0, 7 * U, 1'b0);
    apply_stimulus();
    check_output("rst_mid:strobes", obs_q.size(), 0);
    check_output("rst_mid:held_len", int'(CHAR_LEN), 0);
    segs.delete();
    add_seg(1'b0, 10, 1'b0); add_seg(1'b1, U, 1'b0); add_seg(1'b0, 6 * U + G + 8, 1'b0);
    run_phase(1'b0, "after_rst");

    for (int p = 0; p < 25; p++) begin
      gen_random();
      run_phase(1'b1, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
